// File: rtl/taxi_eth_phy_10g_rx_gearbox.sv
// RX gearbox: repacks transceiver words (bit 0 earliest) into 66-bit 10GBASE-R blocks,
// dropping one buffered bit per rising edge of serdes_rx_bitslip.
module taxi_eth_phy_10g_rx_gearbox #(
    parameter int IN_W   = 32,
    parameter int DATA_W = 64,
    parameter int HDR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] serdes_rx_data,
    output logic [HDR_W-1:0]  serdes_rx_hdr,
    output logic              serdes_rx_valid,
    input  logic              serdes_rx_bitslip
);

    localparam int BUF_W = IN_W + 65;

    if (IN_W != 32 && IN_W != 64) begin : g_bad_in_w
        $fatal(1, "IN_W must be 32 or 64");
    end
    if (DATA_W != 64) begin : g_bad_data_w
        $fatal(1, "DATA_W must be 64");
    end
    if (HDR_W != 2) begin : g_bad_hdr_w
        $fatal(1, "HDR_W must be 2");
    end

    logic [BUF_W-1:0] buf_reg;
    logic [BUF_W-1:0] buf_next;
    logic [7:0]       cnt_reg;
    logic [7:0]       total;
    logic             slip_pending_reg;
    logic             bitslip_d_reg;
    logic             slip_now;
    logic             slip_pending_next;
    logic             emit;
    logic [65:0]      blk;

    // Bits above cnt_reg are always zero, so appending is a plain OR at the fill point.
    always_comb begin
        buf_next = buf_reg;
        total    = cnt_reg;
        if (in_valid) begin
            buf_next = buf_reg | ({{65{1'b0}}, in_data} << cnt_reg);
            total    = cnt_reg + 8'(IN_W);
        end

        slip_now          = slip_pending_reg | (serdes_rx_bitslip & ~bitslip_d_reg);
        slip_pending_next = slip_now;
        if (slip_now && total != 8'd0) begin
            buf_next          = buf_next >> 1;
            total             = total - 8'd1;
            slip_pending_next = 1'b0;
        end

        emit = total >= 8'd66;
        blk  = buf_next[65:0];
        if (emit) begin
            buf_next = buf_next >> 66;
            total    = total - 8'd66;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_reg          <= '0;
            cnt_reg          <= '0;
            slip_pending_reg <= 1'b0;
            bitslip_d_reg    <= 1'b0;
            serdes_rx_valid  <= 1'b0;
            serdes_rx_data   <= '0;
            serdes_rx_hdr    <= '0;
        end else begin
            buf_reg          <= buf_next;
            cnt_reg          <= total;
            slip_pending_reg <= slip_pending_next;
            bitslip_d_reg    <= serdes_rx_bitslip;
            serdes_rx_valid  <= emit;
            // Data outputs hold their last block between valid pulses.
            if (emit) begin
                serdes_rx_hdr  <= blk[HDR_W-1:0];
                serdes_rx_data <= blk[HDR_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_taxi_eth_phy_10g_rx_gearbox.sv
// Bench for the RX gearbox: bit-queue reference model, known aligned block streams,
// slips, valid gaps, deferred slip and reset mid-stream.
module tb_taxi_eth_phy_10g_rx_gearbox;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        serdes_rx_bitslip = 1'b0;
    logic [63:0] rx_data;
    logic [1:0]  rx_hdr;
    logic        rx_valid;

    logic [63:0] in_data64 = '0;
    logic        in_valid64 = 1'b0;
    logic        bitslip64 = 1'b0;
    logic [63:0] rx_data64;
    logic [1:0]  rx_hdr64;
    logic        rx_valid64;

    always #5 clk = ~clk;

    taxi_eth_phy_10g_rx_gearbox #(.IN_W(32), .DATA_W(64), .HDR_W(2)) dut32 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .serdes_rx_data(rx_data), .serdes_rx_hdr(rx_hdr), .serdes_rx_valid(rx_valid),
        .serdes_rx_bitslip(serdes_rx_bitslip)
    );

    taxi_eth_phy_10g_rx_gearbox #(.IN_W(64), .DATA_W(64), .HDR_W(2)) dut64 (
        .clk(clk), .rst(rst), .in_data(in_data64), .in_valid(in_valid64),
        .serdes_rx_data(rx_data64), .serdes_rx_hdr(rx_hdr64), .serdes_rx_valid(rx_valid64),
        .serdes_rx_bitslip(bitslip64)
    );

    int n_checks = 0;
    int n_pass = 0;

    logic [65:0] blk [0:31];
    bit          strm [0:2143];

    bit          mq[$];
    bit          mpend;
    bit          md;
    logic [65:0] exp_q[$];
    logic [65:0] got_q[$];
    int          vld_err;
    int          gap_err;

    logic [31:0] t1_w [0:2];

    task automatic build_blocks();
        for (int i = 0; i < 32; i++) begin
            blk[i][1:0]  = (i % 2 == 0) ? 2'b01 : 2'b10;
            blk[i][65:2] = 64'h0123_4567_89ab_0000 + 64'(i);
        end
    endtask

    task automatic build_stream(input int garbage);
        for (int j = 0; j < 2144; j++) strm[j] = 1'b0;
        for (int j = 0; j < garbage; j++) strm[j] = 1'($urandom_range(0, 1));
        for (int j = 0; j < 2112; j++) strm[garbage + j] = blk[j / 66][j % 66];
    endtask

    function automatic logic [31:0] word32(input int w);
        logic [31:0] r;
        for (int b = 0; b < 32; b++) r[b] = strm[32 * w + b];
        return r;
    endfunction

    task automatic clear_scoreboard();
        exp_q.delete();
        got_q.delete();
        vld_err = 0;
        gap_err = 0;
    endtask

    task automatic do_reset(input logic slip, input logic v);
        rst = 1'b1;
        serdes_rx_bitslip = slip;
        in_valid = v;
        in_data = $urandom;
        in_valid64 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        serdes_rx_bitslip = 1'b0;
        in_valid = 1'b0;
        mq.delete();
        mpend = 1'b0;
        md = 1'b0;
        clear_scoreboard();
    endtask

    // One clock of the 32-bit DUT; the model keeps the received bits as a plain bit queue.
    task automatic step(input logic v, input logic [31:0] d, input logic s);
        logic [65:0] b66;
        logic        mexp;
        in_valid = v;
        in_data = d;
        serdes_rx_bitslip = s;
        @(posedge clk);
        mexp = 1'b0;
        if (s && !md) mpend = 1'b1;
        md = s;
        if (v) for (int b = 0; b < 32; b++) mq.push_back(d[b]);
        if (mpend && mq.size() >= 1) begin
            void'(mq.pop_front());
            mpend = 1'b0;
        end
        if (mq.size() >= 66) begin
            for (int i = 0; i < 66; i++) b66[i] = mq.pop_front();
            exp_q.push_back(b66);
            mexp = 1'b1;
        end
        #1;
        if (rx_valid !== mexp) vld_err++;
        if (!v && rx_valid !== 1'b0) gap_err++;
        if (rx_valid === 1'b1) got_q.push_back({rx_data, rx_hdr});
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 64'd0) $display("FAIL reset_data: got %h want 0", rx_data); else n_pass++;
        n_checks++; if (rx_hdr !== 2'd0) $display("FAIL reset_hdr: got %b want 0", rx_hdr); else n_pass++;
        n_checks++; if (dut32.cnt_reg !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", dut32.cnt_reg); else n_pass++;
        n_checks++; if (rx_valid64 !== 1'b0) $display("FAIL reset_valid64: got %b want 0", rx_valid64); else n_pass++;
    endtask

    task automatic test_first_block();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) t1_w[i] = $urandom;
        step(1'b1, t1_w[0], 1'b0);
        step(1'b1, t1_w[1], 1'b0);
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL first_early_valid: got %b want 0", rx_valid); else n_pass++;
        step(1'b1, t1_w[2], 1'b0);
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", rx_valid); else n_pass++;
        n_checks++; if (rx_hdr !== t1_w[0][1:0]) $display("FAIL first_hdr: got %b want %b", rx_hdr, t1_w[0][1:0]); else n_pass++;
        n_checks++;
        if (rx_data !== {t1_w[2][1:0], t1_w[1], t1_w[0][31:2]})
            $display("FAIL first_data: got %h want %h", rx_data, {t1_w[2][1:0], t1_w[1], t1_w[0][31:2]});
        else n_pass++;
        n_checks++; if (dut32.cnt_reg !== 8'd30) $display("FAIL first_cnt: got %0d want 30", dut32.cnt_reg); else n_pass++;
    endtask

    task automatic test_aligned32();
        build_stream(0);
        do_reset(1'b0, 1'b0);
        for (int w = 0; w < 66; w++) step(1'b1, word32(w), 1'b0);
        n_checks++; if (got_q.size() != 32) $display("FAIL al32_count: got %0d want 32", got_q.size()); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (got_q.size() <= i || got_q[i] !== blk[i]) $display("FAIL al32_blk%0d: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 66'bx, blk[i]);
            else n_pass++;
        end
        n_checks++; if (dut32.cnt_reg !== 8'd0) $display("FAIL al32_cnt: got %0d want 0", dut32.cnt_reg); else n_pass++;
        n_checks++; if (vld_err != 0) $display("FAIL al32_timing: got %0d want 0", vld_err); else n_pass++;
    endtask

    task automatic test_aligned64();
        logic [65:0] g64[$];
        build_stream(0);
        do_reset(1'b0, 1'b0);
        for (int w = 0; w < 33; w++) begin
            for (int b = 0; b < 64; b++) in_data64[b] = strm[64 * w + b];
            in_valid64 = 1'b1;
            @(posedge clk);
            #1;
            if (rx_valid64 === 1'b1) g64.push_back({rx_data64, rx_hdr64});
        end
        in_valid64 = 1'b0;
        n_checks++; if (g64.size() != 32) $display("FAIL al64_count: got %0d want 32", g64.size()); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (g64.size() <= i || g64[i] !== blk[i]) $display("FAIL al64_blk%0d: got %h want %h", i, (g64.size() > i) ? g64[i] : 66'bx, blk[i]);
            else n_pass++;
        end
        n_checks++; if (dut64.cnt_reg !== 8'd0) $display("FAIL al64_cnt: got %0d want 0", dut64.cnt_reg); else n_pass++;
    endtask

    task automatic test_bitslip();
        logic s;
        build_stream(3);
        do_reset(1'b0, 1'b0);
        for (int w = 0; w < 67; w++) begin
            s = (w == 0 || w == 1 || w == 3 || w == 4 || w == 6 || w == 7);
            step(1'b1, word32(w), s);
        end
        n_checks++; if (got_q.size() != 32) $display("FAIL slip_count: got %0d want 32", got_q.size()); else n_pass++;
        n_checks++; if (vld_err != 0) $display("FAIL slip_timing: got %0d want 0", vld_err); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (got_q.size() <= i || exp_q.size() <= i || got_q[i] !== exp_q[i]) $display("FAIL slip_model%0d: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 66'bx, (exp_q.size() > i) ? exp_q[i] : 66'bx);
            else n_pass++;
        end
        // Three slips remove three bits, so everything from block 3 on is realigned.
        for (int i = 3; i < 32; i++) begin
            n_checks++;
            if (got_q.size() <= i || got_q[i] !== blk[i]) $display("FAIL slip_aligned%0d: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 66'bx, blk[i]);
            else n_pass++;
        end
    endtask

    task automatic test_slip_hold();
        build_stream(1);
        do_reset(1'b0, 1'b0);
        for (int w = 0; w < 67; w++) step(1'b1, word32(w), w < 10);
        n_checks++; if (got_q.size() != 32) $display("FAIL hold_count: got %0d want 32", got_q.size()); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (got_q.size() <= i || got_q[i] !== blk[i]) $display("FAIL hold_blk%0d: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 66'bx, blk[i]);
            else n_pass++;
        end
    endtask

    task automatic test_valid_gaps();
        int gaps;
        build_stream(0);
        do_reset(1'b0, 1'b0);
        gaps = 0;
        for (int w = 0; w < 66; w++) begin
            if ($urandom_range(0, 2) == 0) begin
                int len = $urandom_range(1, 7);
                for (int k = 0; k < len; k++) step(1'b0, $urandom, 1'b0);
                gaps++;
            end
            step(1'b1, word32(w), 1'b0);
        end
        n_checks++; if (got_q.size() != 32) $display("FAIL gap_count: got %0d want 32", got_q.size()); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (got_q.size() <= i || got_q[i] !== blk[i]) $display("FAIL gap_blk%0d: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 66'bx, blk[i]);
            else n_pass++;
        end
        n_checks++; if (gap_err != 0) $display("FAIL gap_valid_in_gap: got %0d want 0 (gaps %0d)", gap_err, gaps); else n_pass++;
        n_checks++; if (vld_err != 0) $display("FAIL gap_timing: got %0d want 0", vld_err); else n_pass++;
    endtask

    task automatic test_deferred_slip();
        logic [31:0] w [0:2];
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        step(1'b0, $urandom, 1'b0);
        step(1'b0, $urandom, 1'b1);
        step(1'b0, $urandom, 1'b0);
        step(1'b0, $urandom, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, w[i], 1'b0);
        n_checks++; if (got_q.size() != 1) $display("FAIL defer_count: got %0d want 1", got_q.size()); else n_pass++;
        n_checks++; if (rx_hdr !== w[0][2:1]) $display("FAIL defer_hdr: got %b want %b", rx_hdr, w[0][2:1]); else n_pass++;
        n_checks++;
        if (rx_data !== {w[2][2:0], w[1], w[0][31:3]}) $display("FAIL defer_data: got %h want %h", rx_data, {w[2][2:0], w[1], w[0][31:3]});
        else n_pass++;
        n_checks++; if (dut32.cnt_reg !== 8'd29) $display("FAIL defer_cnt: got %0d want 29", dut32.cnt_reg); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int guard;
        do_reset(1'b0, 1'b0);
        guard = 0;
        while (mq.size() != 40 && guard < 60) begin
            step(1'b1, $urandom, 1'b0);
            guard++;
        end
        n_checks++; if (dut32.cnt_reg !== 8'd40) $display("FAIL mid_fill_cnt: got %0d want 40", dut32.cnt_reg); else n_pass++;
        // Slip rising in the reset cycle, with valid data, must all be ignored.
        do_reset(1'b1, 1'b1);
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 64'd0) $display("FAIL mid_data: got %h want 0", rx_data); else n_pass++;
        n_checks++; if (rx_hdr !== 2'd0) $display("FAIL mid_hdr: got %b want 0", rx_hdr); else n_pass++;
        n_checks++; if (dut32.cnt_reg !== 8'd0) $display("FAIL mid_cnt: got %0d want 0", dut32.cnt_reg); else n_pass++;
        for (int i = 0; i < 3; i++) step(1'b1, t1_w[i], 1'b0);
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL mid_rerun_valid: got %b want 1", rx_valid); else n_pass++;
        n_checks++; if (rx_hdr !== t1_w[0][1:0]) $display("FAIL mid_rerun_hdr: got %b want %b", rx_hdr, t1_w[0][1:0]); else n_pass++;
        n_checks++;
        if (rx_data !== {t1_w[2][1:0], t1_w[1], t1_w[0][31:2]})
            $display("FAIL mid_rerun_data: got %h want %h", rx_data, {t1_w[2][1:0], t1_w[1], t1_w[0][31:2]});
        else n_pass++;
        n_checks++; if (dut32.cnt_reg !== 8'd30) $display("FAIL mid_rerun_cnt: got %0d want 30", dut32.cnt_reg); else n_pass++;
        n_checks++; if (vld_err != 0) $display("FAIL mid_rerun_timing: got %0d want 0", vld_err); else n_pass++;
    endtask

    initial begin
        build_blocks();
        @(posedge clk);
        #1;
        test_reset();
        test_first_block();
        test_aligned32();
        test_aligned64();
        test_bitslip();
        test_slip_hold();
        test_valid_gaps();
        test_deferred_slip();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
